// File: rtl/apb_sl_frontend.sv
// APB3 slave front end: CPU writes become tagged command-FIFO pushes, RSP reads pop the response FIFO.
// Define APB_SL_TIMEOUT_EN to build the WAIT-state timeout (wait counter and TOERR).
module apb_sl_frontend #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        cmd_full,
  output logic [33:0] cmd_data,
  output logic        cmd_inc,
  input  logic        rsp_empty,
  input  logic [33:0] rsp_data,
  output logic        rsp_inc,
  output logic        irq
);
  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_PUSH = 2;
  localparam int S_POP  = 3;
  localparam int S_ACK  = 4;
  localparam int S_ERR  = 5;
  localparam logic [5:0] ST_IDLE = 6'b000001;

  localparam logic [5:0] IDX_CHAN   = 6'h00;
  localparam logic [5:0] IDX_CONFIG = 6'h01;
  localparam logic [5:0] IDX_DATA   = 6'h02;
  localparam logic [5:0] IDX_RSP    = 6'h03;
  localparam logic [5:0] IDX_STATUS = 6'h04;
  localparam logic [5:0] IDX_IRQEN  = 6'h05;

  logic [5:0]  state_q, state_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [33:0] cmd_data_q, cmd_data_d;
  logic        cmd_inc_q, cmd_inc_d;
  logic        rsp_inc_q, rsp_inc_d;
  logic        irq_q, irq_d;
  logic [1:0]  mod_q, mod_d;
  logic [1:0]  irqen_q, irqen_d;
  logic        addrerr_q, addrerr_d;
  logic        toerr_q;

  logic [5:0]  reg_idx;
  logic        access, is_push, is_pop, is_csr, is_illegal, res_ready, timeout_hit;
  logic        csr_take, status_w1c, irqen_wr, addrerr_set;
  logic [33:0] push_word;
  logic [31:0] status_word, csr_rdata;
  logic        unused_addr_lsb;

  assign reg_idx         = paddr[7:2];
  assign unused_addr_lsb = ^paddr[1:0];
  assign access          = psel & penable;
  assign is_push    = pwrite & ((reg_idx == IDX_CHAN) | (reg_idx == IDX_CONFIG) | (reg_idx == IDX_DATA));
  assign is_pop     = ~pwrite & (reg_idx == IDX_RSP);
  assign is_csr     = (reg_idx == IDX_STATUS) | (reg_idx == IDX_IRQEN);
  assign is_illegal = ~(is_push | is_pop | is_csr);
  assign res_ready  = is_push ? ~cmd_full : ~rsp_empty;

  always_comb begin
    case (reg_idx)
      IDX_CHAN:   push_word = {2'd3, pwdata};
      IDX_CONFIG: push_word = {2'd0, pwdata};
      default:    push_word = {2'd1, pwdata};
    endcase
  end

  assign status_word = {22'd0, addrerr_q, toerr_q, 4'd0, mod_q, cmd_full, ~rsp_empty};
  assign csr_rdata   = (reg_idx == IDX_STATUS) ? status_word : {30'd0, irqen_q};

  // Next-state logic; the FSM only acts on an APB access phase.
  always_comb begin
    state_d = '0;
    case (1'b1)
      state_q[S_IDLE]: begin
        if (!access)                 state_d[S_IDLE] = 1'b1;
        else if (is_illegal)         state_d[S_ERR]  = 1'b1;
        else if (is_csr)             state_d[S_ACK]  = 1'b1;
        else if (!res_ready)         state_d[S_WAIT] = 1'b1;
        else if (is_push)            state_d[S_PUSH] = 1'b1;
        else                         state_d[S_POP]  = 1'b1;
      end
      state_q[S_WAIT]: begin
        if (!psel)                   state_d[S_IDLE] = 1'b1;
        else if (res_ready && is_push) state_d[S_PUSH] = 1'b1;
        else if (res_ready)          state_d[S_POP]  = 1'b1;
        else if (timeout_hit)        state_d[S_ERR]  = 1'b1;
        else                         state_d[S_WAIT] = 1'b1;
      end
      default:                       state_d[S_IDLE] = 1'b1;
    endcase
  end

  // Output values are prepared from the next state so every output is a flop.
  always_comb begin
    pready_d   = state_d[S_PUSH] | state_d[S_POP] | state_d[S_ACK] | state_d[S_ERR];
    pslverr_d  = state_d[S_ERR];
    cmd_inc_d  = state_d[S_PUSH];
    rsp_inc_d  = state_d[S_POP];
    cmd_data_d = '0;
    prdata_d   = '0;
    if (state_d[S_PUSH]) cmd_data_d = push_word;
    if (state_d[S_POP])                 prdata_d = rsp_data[31:0];
    else if (state_d[S_ACK] && !pwrite) prdata_d = csr_rdata;
  end

  assign csr_take    = state_q[S_IDLE] & state_d[S_ACK];
  assign status_w1c  = csr_take & pwrite & (reg_idx == IDX_STATUS);
  assign irqen_wr    = csr_take & pwrite & (reg_idx == IDX_IRQEN);
  assign addrerr_set = state_q[S_IDLE] & state_d[S_ERR];

  // Sticky bits: a set in the same cycle as a clear wins.
  always_comb begin
    mod_d     = state_d[S_POP] ? rsp_data[33:32] : mod_q;
    irqen_d   = irqen_wr ? pwdata[1:0] : irqen_q;
    addrerr_d = (addrerr_q & ~(status_w1c & pwdata[9])) | addrerr_set;
    irq_d     = (irqen_q[0] & ~rsp_empty) | (irqen_q[1] & (toerr_q | addrerr_q));
  end

`ifdef APB_SL_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        toerr_d;

  // Counter is 1 in the first WAIT cycle, so the error lands after TIMEOUT_CYCLES+1 wait states.
  assign timeout_hit = (wait_cnt_q == TIMEOUT_LIM);

  always_comb begin
    wait_cnt_d = '0;
    if (state_d[S_WAIT]) wait_cnt_d = state_q[S_WAIT] ? wait_cnt_q + 16'd1 : 16'd1;
    toerr_d = (toerr_q & ~(status_w1c & pwdata[8])) | (state_q[S_WAIT] & state_d[S_ERR]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      toerr_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      toerr_q    <= toerr_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign toerr_q            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      cmd_data_q <= '0;
      cmd_inc_q  <= 1'b0;
      rsp_inc_q  <= 1'b0;
      irq_q      <= 1'b0;
      mod_q      <= '0;
      irqen_q    <= '0;
      addrerr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      cmd_data_q <= cmd_data_d;
      cmd_inc_q  <= cmd_inc_d;
      rsp_inc_q  <= rsp_inc_d;
      irq_q      <= irq_d;
      mod_q      <= mod_d;
      irqen_q    <= irqen_d;
      addrerr_q  <= addrerr_d;
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign cmd_data = cmd_data_q;
  assign cmd_inc  = cmd_inc_q;
  assign rsp_inc  = rsp_inc_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_apb_sl_frontend.sv
// Directed self-checking bench for apb_sl_frontend (TIMEOUT_CYCLES=4); timeout scenario
// follows whether APB_SL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_sl_frontend;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        cmd_full;
  logic [33:0] cmd_data;
  logic        cmd_inc;
  logic        rsp_empty;
  logic [33:0] rsp_data;
  logic        rsp_inc;
  logic        irq;

  always #5 clk = ~clk;

  apb_sl_frontend #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cmd_full(cmd_full), .cmd_data(cmd_data), .cmd_inc(cmd_inc),
    .rsp_empty(rsp_empty), .rsp_data(rsp_data), .rsp_inc(rsp_inc), .irq(irq)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Strobe monitor: counts pushes/pops, remembers the last pushed word, flags adjacent strobes.
  int          cmd_cnt = 0, rsp_cnt = 0, b2b_cnt = 0;
  logic [33:0] last_cmd = '0;
  logic        prev_cmd = 1'b0, prev_rsp = 1'b0;
  always @(negedge clk) begin
    if (cmd_inc) begin
      cmd_cnt  <= cmd_cnt + 1;
      last_cmd <= cmd_data;
    end
    if (rsp_inc) rsp_cnt <= rsp_cnt + 1;
    if ((cmd_inc && prev_cmd) || (rsp_inc && prev_rsp)) b2b_cnt <= b2b_cnt + 1;
    prev_cmd <= cmd_inc;
    prev_rsp <= rsp_inc;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one APB transfer. cmd_full is released at the start of access cycle release_at+1
  // (release_at=0: never). Aborts by dropping psel after max_cycles without pready.
  task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                          input int release_at, input int max_cycles,
                          output int waits, output logic [31:0] rdata,
                          output logic err, output logic done);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    step();
    penable = 1'b1;
    done = 1'b0; waits = max_cycles; rdata = '0; err = 1'b0;
    for (int c = 2; c <= max_cycles + 1; c++) begin
      step();
      if (release_at > 0 && c == release_at + 1) cmd_full = 1'b0;
      if (pready) begin
        done = 1'b1; waits = c - 1; rdata = prdata; err = pslverr;
        break;
      end
    end
    if (done) step();
    psel = 1'b0; penable = 1'b0;
    if (!done) begin
      step();
      step();
    end
    $display("xfer addr=%02h wr=%0d wdata=%08h waits=%0d rdata=%08h err=%0d done=%0d",
             addr, wr, wdata, waits, rdata, err, done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    cmd_full = 0; rsp_empty = 1; rsp_data = '0;
    step(); step(); step();
    n_cmp++;
    if ({pready, pslverr, prdata, cmd_inc, cmd_data, rsp_inc, irq} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pready=%0d pslverr=%0d prdata=%08h cmd_inc=%0d cmd_data=%09h rsp_inc=%0d irq=%0d, want all 0",
               pready, pslverr, prdata, cmd_inc, cmd_data, rsp_inc, irq);
    end
    rst_n = 1'b1;
    step();
    begin
      int w; logic [31:0] rd; logic e, d;
      apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
      n_cmp++;
      if (rd !== 32'h0 || e !== 1'b0 || w != 1) begin
        n_fail++; $display("FAIL reset_status: got %08h err=%0d waits=%0d, want 00000000 err=0 waits=1", rd, e, w);
      end
      apb_xfer(8'h14, 1'b0, 32'h0, 0, 20, w, rd, e, d);
      n_cmp++;
      if (rd !== 32'h0) begin
        n_fail++; $display("FAIL reset_irqen: got %08h, want 00000000", rd);
      end
    end
  endtask

  task automatic test_push();
    int w; logic [31:0] rd; logic e, d; int c0;
    c0 = cmd_cnt;
    apb_xfer(8'h00, 1'b1, 32'h0000_0005, 0, 20, w, rd, e, d);
    n_cmp++;
    if (w != 1 || e !== 1'b0 || d !== 1'b1) begin
      n_fail++; $display("FAIL chan_latency: got waits=%0d err=%0d done=%0d, want waits=1 err=0 done=1", w, e, d);
    end
    n_cmp++;
    if (cmd_cnt - c0 != 1 || last_cmd !== 34'h3_0000_0005) begin
      n_fail++; $display("FAIL chan_push: got %0d pushes word=%09h, want 1 push word=300000005", cmd_cnt - c0, last_cmd);
    end
    c0 = cmd_cnt;
    apb_xfer(8'h04, 1'b1, 32'hDEAD_BEEF, 0, 20, w, rd, e, d);
    n_cmp++;
    if (cmd_cnt - c0 != 1 || last_cmd !== 34'h0_DEAD_BEEF || w != 1) begin
      n_fail++; $display("FAIL config_push: got %0d pushes word=%09h waits=%0d, want 1 push word=0deadbeef waits=1", cmd_cnt - c0, last_cmd, w);
    end
  endtask

  task automatic test_blocked_push();
    int w; logic [31:0] rd; logic e, d; int c0; int n;
`ifdef APB_SL_TIMEOUT_EN
    n = 3;
`else
    n = 10;
`endif
    c0 = cmd_cnt;
    cmd_full = 1'b1;
    apb_xfer(8'h08, 1'b1, 32'hA5A5_A5A5, n, 40, w, rd, e, d);
    n_cmp++;
    if (w != n + 1 || e !== 1'b0 || d !== 1'b1) begin
      n_fail++; $display("FAIL blocked_latency: got waits=%0d err=%0d done=%0d, want waits=%0d err=0 done=1", w, e, d, n + 1);
    end
    n_cmp++;
    if (cmd_cnt - c0 != 1 || last_cmd !== 34'h1_A5A5_A5A5) begin
      n_fail++; $display("FAIL blocked_push: got %0d pushes word=%09h, want 1 push word=1a5a5a5a5", cmd_cnt - c0, last_cmd);
    end
    cmd_full = 1'b0;
  endtask

  task automatic test_timeout();
    int w; logic [31:0] rd; logic e, d; int r0;
    r0 = rsp_cnt;
    rsp_empty = 1'b1;
`ifdef APB_SL_TIMEOUT_EN
    apb_xfer(8'h0C, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (d !== 1'b1 || e !== 1'b1 || w != 5 || rd !== 32'h0) begin
      n_fail++; $display("FAIL timeout_err: got done=%0d err=%0d waits=%0d rdata=%08h, want done=1 err=1 waits=5 rdata=0", d, e, w, rd);
    end
    n_cmp++;
    if (rsp_cnt != r0) begin
      n_fail++; $display("FAIL timeout_no_pop: got %0d pops, want 0", rsp_cnt - r0);
    end
    apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0000_0100) begin
      n_fail++; $display("FAIL timeout_status: got %08h, want 00000100", rd);
    end
    apb_xfer(8'h10, 1'b1, 32'h0000_0100, 0, 20, w, rd, e, d);
`else
    apb_xfer(8'h0C, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (d !== 1'b0) begin
      n_fail++; $display("FAIL wait_hold: got done=%0d, want 0 (no pready while empty)", d);
    end
    n_cmp++;
    if (rsp_cnt != r0) begin
      n_fail++; $display("FAIL abort_no_pop: got %0d pops, want 0", rsp_cnt - r0);
    end
`endif
    apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0 || e !== 1'b0) begin
      n_fail++; $display("FAIL status_clear: got %08h err=%0d, want 00000000 err=0", rd, e);
    end
  endtask

  task automatic test_rsp_read();
    int w; logic [31:0] rd; logic e, d; int r0;
    r0 = rsp_cnt;
    rsp_empty = 1'b0; rsp_data = 34'h2_1234_5678;
    apb_xfer(8'h0C, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h1234_5678 || w != 1 || e !== 1'b0) begin
      n_fail++; $display("FAIL rsp_read: got %08h waits=%0d err=%0d, want 12345678 waits=1 err=0", rd, w, e);
    end
    n_cmp++;
    if (rsp_cnt - r0 != 1) begin
      n_fail++; $display("FAIL rsp_pop: got %0d pops, want 1", rsp_cnt - r0);
    end
    rsp_data = 34'h1_0BAD_F00D;
    apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0000_0009) begin
      n_fail++; $display("FAIL status_mod2: got %08h, want 00000009", rd);
    end
    apb_xfer(8'h0C, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0BAD_F00D || rsp_cnt - r0 != 2) begin
      n_fail++; $display("FAIL rsp_read2: got %08h pops=%0d, want 0badf00d pops=2", rd, rsp_cnt - r0);
    end
    rsp_empty = 1'b1;
    apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin
      n_fail++; $display("FAIL status_mod1: got %08h, want 00000004", rd);
    end
  endtask

  task automatic test_addr_err();
    int w; logic [31:0] rd; logic e, d; int r0, c0;
    r0 = rsp_cnt; c0 = cmd_cnt;
    apb_xfer(8'h0C, 1'b1, 32'hFFFF_FFFF, 0, 20, w, rd, e, d);
    n_cmp++;
    if (e !== 1'b1 || w != 1 || rd !== 32'h0 || rsp_cnt != r0 || cmd_cnt != c0) begin
      n_fail++; $display("FAIL rsp_write_err: got err=%0d waits=%0d rdata=%08h strobes=%0d, want err=1 waits=1 rdata=0 strobes=0",
                         e, w, rd, (rsp_cnt - r0) + (cmd_cnt - c0));
    end
    apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0000_0204) begin
      n_fail++; $display("FAIL status_addrerr: got %08h, want 00000204", rd);
    end
    apb_xfer(8'h14, 1'b1, 32'h0000_0002, 0, 20, w, rd, e, d);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_err: got irq=%0d, want 1", irq);
    end
    apb_xfer(8'h20, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_err: got err=%0d rdata=%08h, want err=1 rdata=0", e, rd);
    end
    apb_xfer(8'h00, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (e !== 1'b1) begin
      n_fail++; $display("FAIL chan_read_err: got err=%0d, want 1", e);
    end
    apb_xfer(8'h10, 1'b1, 32'h0000_0200, 0, 20, w, rd, e, d);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got irq=%0d, want 0", irq);
    end
    apb_xfer(8'h10, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin
      n_fail++; $display("FAIL status_w1c: got %08h, want 00000004", rd);
    end
    apb_xfer(8'h14, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0000_0002) begin
      n_fail++; $display("FAIL irqen_read: got %08h, want 00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    int w; logic [31:0] rd; logic e, d; int c0, r0;
    c0 = cmd_cnt; r0 = rsp_cnt;
    apb_xfer(8'h04, 1'b1, 32'h0000_0011, 0, 20, w, rd, e, d);
    apb_xfer(8'h04, 1'b1, 32'h0000_0022, 0, 20, w, rd, e, d);
    n_cmp++;
    if (cmd_cnt - c0 != 2 || last_cmd !== 34'h0_0000_0022) begin
      n_fail++; $display("FAIL b2b_push: got %0d pushes last=%09h, want 2 last=000000022", cmd_cnt - c0, last_cmd);
    end
    rsp_empty = 1'b0; rsp_data = 34'h3_CAFE_0001;
    apb_xfer(8'h0C, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    apb_xfer(8'h0C, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    rsp_empty = 1'b1;
    n_cmp++;
    if (rsp_cnt - r0 != 2 || rd !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL b2b_pop: got %0d pops rdata=%08h, want 2 rdata=cafe0001", rsp_cnt - r0, rd);
    end
    n_cmp++;
    if (b2b_cnt != 0) begin
      n_fail++; $display("FAIL strobe_spacing: got %0d adjacent strobes, want 0", b2b_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    int w; logic [31:0] rd; logic e, d; int c0;
    rsp_empty = 1'b0;
    apb_xfer(8'h14, 1'b1, 32'h0000_0001, 0, 20, w, rd, e, d);
    c0 = cmd_cnt;
    cmd_full = 1'b1;
    psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h0000_0077;
    step();
    penable = 1'b1;
    step(); step(); step();
    n_cmp++;
    if (pready !== 1'b0 || irq !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got pready=%0d irq=%0d, want pready=0 irq=1", pready, irq);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pready, pslverr, prdata, cmd_inc, cmd_data, rsp_inc, irq} !== 71'd0) begin
      n_fail++; $display("FAIL wait_reset_outputs: got pready=%0d cmd_inc=%0d irq=%0d cmd_data=%09h, want all 0",
                         pready, cmd_inc, irq, cmd_data);
    end
    psel = 1'b0; penable = 1'b0; cmd_full = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (cmd_cnt != c0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got %0d pushes irq=%0d, want 0 pushes irq=0", cmd_cnt - c0, irq);
    end
    apb_xfer(8'h14, 1'b0, 32'h0, 0, 20, w, rd, e, d);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_irqen: got %08h, want 00000000", rd);
    end
    rsp_empty = 1'b1;
  endtask

  initial begin
    test_reset();
    test_push();
    test_blocked_push();
    test_timeout();
    test_rsp_read();
    test_addr_err();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_sl_frontend.md
# apb_sl_frontend

APB3 slave front end for the SL transceiver bridge. It turns CPU register writes into 34-bit tagged command words (2-bit modifier in [33:32], payload in [31:0]) and pushes them into the command FIFO consumed by the channel bridge. It also pops tagged response words produced by the bridge from the response FIFO and presents them on PRDATA. It sits directly upstream of the bridge on the command path and directly downstream of it on the response path; both FIFOs are show-ahead and live in the clk domain.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait states on a blocked push or pop before an error response; range 1..65535.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- psel, penable, pwrite  in  1 each  APB3 control.
- paddr  in  8  byte address; bits [1:0] ignored.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid when pready=1.
- pready  out  1  transfer complete.
- pslverr  out  1  error, valid only with pready=1.
- cmd_full  in  1  command FIFO full.
- cmd_data  out  34  command word.
- cmd_inc  out  1  push strobe, one cycle per word.
- rsp_empty  in  1  response FIFO empty.
- rsp_data  in  34  head-of-FIFO response word.
- rsp_inc  out  1  pop strobe, one cycle per word.
- irq  out  1  level interrupt.

## Operation
- Register map (paddr[7:2]):
  - 0x00 CHAN: W only; pushes {2'd3, pwdata}.
  - 0x04 CONFIG: W only; pushes {2'd0, pwdata}.
  - 0x08 DATA: W only; pushes {2'd1, pwdata}.
  - 0x0C RSP: R only; pops one word and returns rsp_data[31:0]; rsp_data[33:32] is latched into STATUS.MOD.
  - 0x10 STATUS: R; bit0 = !rsp_empty, bit1 = cmd_full, [3:2] = MOD, bit8 = TOERR (sticky), bit9 = ADDRERR (sticky). W1C on bits 8 and 9.
  - 0x14 IRQEN: R/W; bit0 enables the response-available interrupt, bit1 enables the error interrupt.
  - Wrong direction or an unmapped address -> ADDRERR.
- Transfer FSM, one-hot: IDLE, WAIT, PUSH, POP, ACK, ERR. It evaluates only when psel & penable are both high.
  - IDLE, push register, !cmd_full -> PUSH. push register, cmd_full -> WAIT.
  - IDLE, RSP read, !rsp_empty -> POP. RSP read, rsp_empty -> WAIT.
  - IDLE, STATUS/IRQEN access -> ACK. Illegal access -> ERR, and ADDRERR is set.
  - WAIT: the 16-bit wait counter increments every cycle. Resource freed -> PUSH or POP. Counter = TIMEOUT_CYCLES -> ERR, TOERR is set, and no push or pop is performed.
  - PUSH: cmd_inc=1, cmd_data = tagged word, pready=1 -> IDLE.
  - POP: rsp_inc=1, prdata = rsp_data[31:0], MOD latched, pready=1 -> IDLE.
  - ACK: pready=1; register read or write takes effect -> IDLE.
  - ERR: pready=1, pslverr=1, prdata=0 -> IDLE.
  - psel low in WAIT (protocol abort) -> IDLE, no side effects.
- irq is registered: (IRQEN[0] & !rsp_empty) | (IRQEN[1] & (TOERR | ADDRERR)).
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - STATUS sticky bits, MOD, IRQEN and the wait counter are 0.
  - Reset mid-transfer drops the transfer; no strobe is issued.

## Timing
- All outputs are registered from state.
- pready is high for exactly one cycle per transfer.
- Minimum latency: pready in the 2nd access cycle (one wait state) for every transfer.
- Blocked transfer latency:
  - Completes 1 cycle after the resource frees.
  - Errors after exactly TIMEOUT_CYCLES+1 wait states.
- cmd_inc and rsp_inc:
  - Never asserted while cmd_full or rsp_empty was high in the deciding cycle.
  - Never asserted on back-to-back cycles.
- W1C of STATUS in the same cycle as a new error: the set wins.

## Configuration
- APB_SL_TIMEOUT_EN defined: WAIT timeout active as described.
- APB_SL_TIMEOUT_EN undefined:
  - WAIT holds indefinitely until the resource frees or psel drops.
  - No wait counter is built.
  - TOERR reads 0.

## Test plan
- Write 0x00000005 to CHAN with cmd_full=0 -> one cmd_inc, cmd_data=0x3_00000005, pready in 2nd access cycle, pslverr=0.
- Write 0xA5A5A5A5 to DATA with cmd_full=1 for 10 cycles -> pready on wait cycle 11, single push of 0x1_A5A5A5A5.
- Read RSP with rsp_data=0x2_12345678 -> prdata=0x12345678, one rsp_inc, STATUS[3:2]=2.
- TIMEOUT_CYCLES=4, read RSP with rsp_empty=1 held -> pslverr after 5 wait states, STATUS=0x100, no rsp_inc; W1C 0x100 clears it.
- Write to 0x0C and read 0x20 -> pslverr=1, ADDRERR set; IRQEN=0x2 -> irq=1 next cycle.
- Assert rst_n=0 in WAIT -> all outputs 0 immediately, no strobe after release.
